// File: rtl/axi_mst_pkg.sv
// Shared constants and types for the AXI3 master traffic initiator.
// Provides response/burst encodings, reference command and expect layouts
// at the default widths, and the AxSIZE helper.
package axi_mst_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int unsigned PKG_ADDR_W = 32;
  localparam int unsigned PKG_ID_W   = 4;

  // Layouts at the default widths. The initiator builds width-matched
  // equivalents from its own parameters for the internal queues.
  typedef struct packed {
    logic                  write;
    logic [PKG_ADDR_W-1:0] addr;
    logic [3:0]            len;
    logic [PKG_ID_W-1:0]   id;
  } cmd_t;

  typedef struct packed {
    logic [PKG_ID_W-1:0] id;
    logic [3:0]          len;
  } exp_t;

  // AxSIZE = log2(bytes per beat); data_w is a power-of-two multiple of 8.
  function automatic logic [2:0] axsize(input int unsigned data_w);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_w) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_mst_fifo.sv
// Small synchronous FIFO with first-word-fall-through head.
// Ports: clk, srst (sync, active high), push/din, pop, full, empty, head.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Push while full and pop while empty are ignored.
module axi_mst_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_mst_initiator.sv
// AXI3 master traffic initiator.
// Accepts burst commands (in_cmd_*), issues AW/W or AR with an
// address-derived data pattern, and checks B/R responses in issue order
// against expected ID, length and response code.
// Ports: aclk/srst; command handshake; AW, W, B, AR, R channels;
// completion counters out_wr_done_cnt/out_rd_done_cnt; sticky error flags.
module axi_mst_initiator
  import axi_mst_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W   = 32,
  parameter int unsigned AXI_ID_W     = 4,
  parameter int unsigned AXI_DATA_W   = 32,
  parameter int unsigned MST_OSTD_NUM = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    aclk,
  input  logic                    srst,
  input  logic                    in_cmd_valid,
  output logic                    out_cmd_ready,
  input  logic                    in_cmd_write,
  input  logic [AXI_ADDR_W-1:0]   in_cmd_addr,
  input  logic [3:0]              in_cmd_len,
  input  logic [AXI_ID_W-1:0]     in_cmd_id,
  output logic                    out_awvalid,
  input  logic                    in_awready,
  output logic [AXI_ADDR_W-1:0]   out_awaddr,
  output logic [3:0]              out_awlen,
  output logic [AXI_ID_W-1:0]     out_awid,
  output logic [2:0]              out_awsize,
  output logic [1:0]              out_awburst,
  output logic                    out_wvalid,
  input  logic                    in_wready,
  output logic [AXI_DATA_W-1:0]   out_wdata,
  output logic [AXI_DATA_W/8-1:0] out_wstrb,
  output logic                    out_wlast,
  output logic [AXI_ID_W-1:0]     out_wid,
  input  logic                    in_bvalid,
  output logic                    out_bready,
  input  logic [AXI_ID_W-1:0]     in_bid,
  input  logic [1:0]              in_bresp,
  output logic                    out_arvalid,
  input  logic                    in_arready,
  output logic [AXI_ADDR_W-1:0]   out_araddr,
  output logic [3:0]              out_arlen,
  output logic [AXI_ID_W-1:0]     out_arid,
  output logic [2:0]              out_arsize,
  output logic [1:0]              out_arburst,
  input  logic                    in_rvalid,
  output logic                    out_rready,
  input  logic [AXI_ID_W-1:0]     in_rid,
  input  logic [1:0]              in_rresp,
  input  logic [AXI_DATA_W-1:0]   in_rdata,
  input  logic                    in_rlast,
  output logic [CNT_W-1:0]        out_wr_done_cnt,
  output logic [CNT_W-1:0]        out_rd_done_cnt,
  output logic                    out_err_bresp,
  output logic                    out_err_bid,
  output logic                    out_err_rresp,
  output logic                    out_err_rid,
  output logic                    out_err_rlast
);

  localparam int unsigned BYTES = AXI_DATA_W / 8;
  localparam int unsigned OW    = $clog2(MST_OSTD_NUM) + 1;
  localparam int unsigned SUM_W = (AXI_ADDR_W > AXI_DATA_W) ? AXI_ADDR_W : AXI_DATA_W;
  localparam logic [2:0]  AXSZ  = axsize(AXI_DATA_W);

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [3:0]            len;
    logic [AXI_ADDR_W-1:0] addr;
  } wq_ent_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [3:0]          len;
  } rq_ent_t;

  logic                  aw_vld, ar_vld, resp_rdy;
  logic [AXI_ADDR_W-1:0] aw_addr, ar_addr;
  logic [3:0]            aw_len, ar_len, w_beat, r_beat;
  logic [AXI_ID_W-1:0]   aw_id, ar_id;
  logic [OW-1:0]         wr_ostd, rd_ostd;

  wq_ent_t             wq_head;
  rq_ent_t             rq_head;
  logic [AXI_ID_W-1:0] bq_head;
  logic                wq_full, wq_empty, bq_full, bq_empty, rq_full, rq_empty;

  logic cmd_ready_w, cmd_ready_r, cmd_fire;
  logic aw_fire, w_valid, w_last, w_fire, w_done, b_fire, b_pop;
  logic ar_fire, r_fire, r_end;
  logic [SUM_W-1:0] wsum;
  logic unused_sink;

  assign cmd_ready_w   = !aw_vld && (wr_ostd < OW'(MST_OSTD_NUM)) && !wq_full;
  assign cmd_ready_r   = !ar_vld && (rd_ostd < OW'(MST_OSTD_NUM)) && !rq_full;
  assign out_cmd_ready = in_cmd_write ? cmd_ready_w : cmd_ready_r;
  assign cmd_fire      = in_cmd_valid && out_cmd_ready;

  assign aw_fire = aw_vld && in_awready;
  assign ar_fire = ar_vld && in_arready;

  // The W queue only holds bursts whose AW has handshaken, so its head is
  // always the burst to stream. A full B-expect queue stalls W so the
  // wlast ID is never dropped.
  assign w_valid = !wq_empty && !bq_full;
  assign w_last  = (w_beat == wq_head.len);
  assign w_fire  = w_valid && in_wready;
  assign w_done  = w_fire && w_last;
  assign wsum    = SUM_W'(wq_head.addr) + SUM_W'(w_beat) * SUM_W'(BYTES);

  assign b_fire = in_bvalid && resp_rdy;
  assign b_pop  = b_fire && !bq_empty;
  assign r_fire = in_rvalid && resp_rdy;
  assign r_end  = r_fire && !rq_empty && in_rlast;

  // Read data is not checked; fold it into a sink to keep it visibly consumed.
  assign unused_sink = ^in_rdata;

  axi_mst_fifo #(.WIDTH($bits(wq_ent_t)), .DEPTH(MST_OSTD_NUM)) u_wq (
    .clk(aclk), .srst(srst), .push(aw_fire), .din({aw_id, aw_len, aw_addr}),
    .pop(w_done), .full(wq_full), .empty(wq_empty), .head(wq_head)
  );

  axi_mst_fifo #(.WIDTH(AXI_ID_W), .DEPTH(MST_OSTD_NUM)) u_bq (
    .clk(aclk), .srst(srst), .push(w_done), .din(wq_head.id),
    .pop(b_pop), .full(bq_full), .empty(bq_empty), .head(bq_head)
  );

  axi_mst_fifo #(.WIDTH($bits(rq_ent_t)), .DEPTH(MST_OSTD_NUM)) u_rq (
    .clk(aclk), .srst(srst), .push(ar_fire), .din({ar_id, ar_len}),
    .pop(r_end), .full(rq_full), .empty(rq_empty), .head(rq_head)
  );

  always_ff @(posedge aclk) begin
    if (srst) begin
      resp_rdy        <= 1'b0;
      aw_vld          <= 1'b0;
      aw_addr         <= '0;
      aw_len          <= '0;
      aw_id           <= '0;
      ar_vld          <= 1'b0;
      ar_addr         <= '0;
      ar_len          <= '0;
      ar_id           <= '0;
      wr_ostd         <= '0;
      rd_ostd         <= '0;
      w_beat          <= '0;
      r_beat          <= '0;
      out_wr_done_cnt <= '0;
      out_rd_done_cnt <= '0;
      out_err_bresp   <= 1'b0;
      out_err_bid     <= 1'b0;
      out_err_rresp   <= 1'b0;
      out_err_rid     <= 1'b0;
      out_err_rlast   <= 1'b0;
    end else begin
      resp_rdy <= 1'b1;

      if (aw_fire) aw_vld <= 1'b0;
      if (cmd_fire && in_cmd_write) begin
        aw_vld  <= 1'b1;
        aw_addr <= in_cmd_addr;
        aw_len  <= in_cmd_len;
        aw_id   <= in_cmd_id;
      end

      if (ar_fire) ar_vld <= 1'b0;
      if (cmd_fire && !in_cmd_write) begin
        ar_vld  <= 1'b1;
        ar_addr <= in_cmd_addr;
        ar_len  <= in_cmd_len;
        ar_id   <= in_cmd_id;
      end

      case ({aw_fire, b_pop})
        2'b10:   wr_ostd <= wr_ostd + OW'(1);
        2'b01:   wr_ostd <= wr_ostd - OW'(1);
        default: wr_ostd <= wr_ostd;
      endcase

      case ({ar_fire, r_end})
        2'b10:   rd_ostd <= rd_ostd + OW'(1);
        2'b01:   rd_ostd <= rd_ostd - OW'(1);
        default: rd_ostd <= rd_ostd;
      endcase

      if (w_fire) w_beat <= w_last ? 4'd0 : w_beat + 4'd1;

      if (b_fire) begin
        if (in_bresp != AXI_RESP_OKAY) out_err_bresp <= 1'b1;
        if (bq_empty || (in_bid != bq_head)) out_err_bid <= 1'b1;
      end
      if (b_pop) out_wr_done_cnt <= out_wr_done_cnt + CNT_W'(1);

      if (r_fire) begin
        if (in_rresp != AXI_RESP_OKAY) out_err_rresp <= 1'b1;
        if (rq_empty) begin
          out_err_rid <= 1'b1;
        end else begin
          if (in_rid != rq_head.id) out_err_rid <= 1'b1;
          // rlast must land exactly on the final beat; this flags both an
          // early rlast and a beat that should have been last but was not.
          if (in_rlast != (r_beat == rq_head.len)) out_err_rlast <= 1'b1;
          if (in_rlast) begin
            r_beat          <= '0;
            out_rd_done_cnt <= out_rd_done_cnt + CNT_W'(1);
          end else begin
            r_beat <= r_beat + 4'd1;
          end
        end
      end
    end
  end

  assign out_awvalid = aw_vld;
  assign out_awaddr  = aw_addr;
  assign out_awlen   = aw_len;
  assign out_awid    = aw_id;
  assign out_awsize  = AXSZ;
  assign out_awburst = AXI_BURST_INCR;

  assign out_wvalid = w_valid;
  assign out_wdata  = wsum[AXI_DATA_W-1:0];
  assign out_wstrb  = '1;
  assign out_wlast  = w_last;
  assign out_wid    = wq_head.id;

  assign out_arvalid = ar_vld;
  assign out_araddr  = ar_addr;
  assign out_arlen   = ar_len;
  assign out_arid    = ar_id;
  assign out_arsize  = AXSZ;
  assign out_arburst = AXI_BURST_INCR;

  assign out_bready = resp_rdy;
  assign out_rready = resp_rdy;

endmodule

// File: tb/tb_axi_mst_initiator.sv
// Self-checking bench for axi_mst_initiator: table-driven write/read
// vectors, hand-written multi-cycle sequences, and a randomized run
// checked against a transaction-level reference model.
module tb_axi_mst_initiator;

  logic        aclk, srst;
  logic        in_cmd_valid, out_cmd_ready, in_cmd_write;
  logic [31:0] in_cmd_addr;
  logic [3:0]  in_cmd_len, in_cmd_id;
  logic        out_awvalid, in_awready;
  logic [31:0] out_awaddr;
  logic [3:0]  out_awlen, out_awid;
  logic [2:0]  out_awsize;
  logic [1:0]  out_awburst;
  logic        out_wvalid, in_wready;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_wlast;
  logic [3:0]  out_wid;
  logic        in_bvalid, out_bready;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;
  logic        out_arvalid, in_arready;
  logic [31:0] out_araddr;
  logic [3:0]  out_arlen, out_arid;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
  logic        in_rvalid, out_rready;
  logic [3:0]  in_rid;
  logic [1:0]  in_rresp;
  logic [31:0] in_rdata;
  logic        in_rlast;
  logic [15:0] out_wr_done_cnt, out_rd_done_cnt;
  logic        out_err_bresp, out_err_bid, out_err_rresp, out_err_rid, out_err_rlast;

  int n_run  = 0;
  int n_fail = 0;

  axi_mst_initiator #(
    .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32), .MST_OSTD_NUM(4), .CNT_W(16)
  ) dut (
    .aclk(aclk), .srst(srst),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready), .in_cmd_write(in_cmd_write),
    .in_cmd_addr(in_cmd_addr), .in_cmd_len(in_cmd_len), .in_cmd_id(in_cmd_id),
    .out_awvalid(out_awvalid), .in_awready(in_awready), .out_awaddr(out_awaddr),
    .out_awlen(out_awlen), .out_awid(out_awid), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_wvalid(out_wvalid), .in_wready(in_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_wlast(out_wlast), .out_wid(out_wid),
    .in_bvalid(in_bvalid), .out_bready(out_bready), .in_bid(in_bid), .in_bresp(in_bresp),
    .out_arvalid(out_arvalid), .in_arready(in_arready), .out_araddr(out_araddr),
    .out_arlen(out_arlen), .out_arid(out_arid), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .in_rvalid(in_rvalid), .out_rready(out_rready), .in_rid(in_rid), .in_rresp(in_rresp),
    .in_rdata(in_rdata), .in_rlast(in_rlast),
    .out_wr_done_cnt(out_wr_done_cnt), .out_rd_done_cnt(out_rd_done_cnt),
    .out_err_bresp(out_err_bresp), .out_err_bid(out_err_bid), .out_err_rresp(out_err_rresp),
    .out_err_rid(out_err_rid), .out_err_rlast(out_err_rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    in_cmd_valid = 0; in_cmd_write = 0; in_cmd_addr = '0; in_cmd_len = '0; in_cmd_id = '0;
    in_awready = 0; in_wready = 0; in_arready = 0;
    in_bvalid = 0; in_bid = '0; in_bresp = '0;
    in_rvalid = 0; in_rid = '0; in_rresp = '0; in_rdata = '0; in_rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    srst = 1;
    step();
    step();
    srst = 0;
  endtask

  function automatic logic [4:0] errs();
    return {out_err_bresp, out_err_bid, out_err_rresp, out_err_rid, out_err_rlast};
  endfunction

  typedef struct {
    logic [31:0] addr; logic [3:0] len; logic [3:0] id;
    logic [3:0] bid; logic [1:0] bresp; logic e_bid; logic e_bresp;
  } wvec_t;

  typedef struct {
    logic [31:0] addr; logic [3:0] len; logic [3:0] id; logic [3:0] rid;
    int nbeats; int last_at; logic [1:0] rresp;
    logic e_rid; logic e_rlast; logic e_rresp;
  } rvec_t;

  task automatic run_write(input wvec_t v, input string tag);
    int c;
    logic [31:0] e;
    do_reset();
    step();
    in_cmd_valid = 1; in_cmd_write = 1; in_cmd_addr = v.addr; in_cmd_len = v.len; in_cmd_id = v.id;
    in_wready = 1;
    #1 chk({tag, "_cmd_ready"}, out_cmd_ready, 1);
    step();
    in_cmd_valid = 0;
    #1;
    chk({tag, "_awvalid"}, out_awvalid, 1);
    chk({tag, "_awaddr"}, out_awaddr, v.addr);
    chk({tag, "_awlen"}, out_awlen, v.len);
    chk({tag, "_awid"}, out_awid, v.id);
    chk({tag, "_awsize"}, out_awsize, 3'd2);
    chk({tag, "_awburst"}, out_awburst, 2'b01);
    chk({tag, "_no_w_before_aw"}, out_wvalid, 0);
    in_awready = 1;
    step();
    in_awready = 0;
    #1;
    c = 0;
    while (!out_wvalid && c < 20) begin step(); #1; c++; end
    chk({tag, "_w_start"}, out_wvalid, 1);
    for (int k = 0; k <= int'(v.len); k++) begin
      e = v.addr + 32'(k) * 32'd4;
      chk({tag, "_wdata"}, out_wdata, e);
      chk({tag, "_wlast"}, out_wlast, (k == int'(v.len)));
      chk({tag, "_wid"}, out_wid, v.id);
      chk({tag, "_wstrb"}, out_wstrb, 4'hF);
      step();
      #1;
    end
    chk({tag, "_w_idle"}, out_wvalid, 0);
    in_bvalid = 1; in_bid = v.bid; in_bresp = v.bresp;
    step();
    in_bvalid = 0;
    #1;
    chk({tag, "_wr_done"}, out_wr_done_cnt, 16'd1);
    chk({tag, "_err_bid"}, out_err_bid, v.e_bid);
    chk({tag, "_err_bresp"}, out_err_bresp, v.e_bresp);
  endtask

  task automatic run_read(input rvec_t v, input string tag);
    int c;
    do_reset();
    step();
    in_cmd_valid = 1; in_cmd_write = 0; in_cmd_addr = v.addr; in_cmd_len = v.len; in_cmd_id = v.id;
    #1 chk({tag, "_cmd_ready"}, out_cmd_ready, 1);
    step();
    in_cmd_valid = 0;
    #1;
    c = 0;
    while (!out_arvalid && c < 20) begin step(); #1; c++; end
    chk({tag, "_arvalid"}, out_arvalid, 1);
    chk({tag, "_araddr"}, out_araddr, v.addr);
    chk({tag, "_arlen"}, out_arlen, v.len);
    chk({tag, "_arid"}, out_arid, v.id);
    chk({tag, "_arsize"}, out_arsize, 3'd2);
    chk({tag, "_arburst"}, out_arburst, 2'b01);
    in_arready = 1;
    step();
    in_arready = 0;
    for (int i = 0; i < v.nbeats; i++) begin
      in_rvalid = 1; in_rid = v.rid; in_rresp = v.rresp; in_rlast = (i == v.last_at);
      in_rdata = $urandom;
      step();
    end
    in_rvalid = 0; in_rlast = 0;
    #1;
    chk({tag, "_rd_done"}, out_rd_done_cnt, 16'd1);
    chk({tag, "_err_rid"}, out_err_rid, v.e_rid);
    chk({tag, "_err_rlast"}, out_err_rlast, v.e_rlast);
    chk({tag, "_err_rresp"}, out_err_rresp, v.e_rresp);
  endtask

  // Randomized run: model tracks commands awaiting AW/AR, bursts awaiting
  // W beats, and responses the bench owes, all at transaction level.
  typedef struct { logic [31:0] addr; logic [3:0] len; logic [3:0] id; } mcmd_t;
  typedef struct { logic [3:0] id; logic [3:0] len; int beat; } rsp_t;

  task automatic run_random(input int ncmd);
    mcmd_t m_aw[$], m_w[$], m_ar[$], e;
    logic [3:0] bq[$];
    rsp_t rq[$], rr;
    int w_beat_m, issued, n_wr, n_rd;
    logic taken, done, cf, af, wf, arf, bf, rf;
    w_beat_m = 0; issued = 0; n_wr = 0; n_rd = 0; taken = 0; done = 0;
    clear_inputs();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (taken) in_cmd_valid = 0;
      taken = 0;
      if (!in_cmd_valid && issued < ncmd && $urandom_range(0, 3) != 0) begin
        in_cmd_valid = 1;
        in_cmd_write = 1'($urandom_range(0, 1));
        in_cmd_addr  = $urandom & 32'hFFFF_FFFC;
        in_cmd_len   = 4'($urandom_range(0, 7));
        in_cmd_id    = 4'($urandom_range(0, 15));
      end
      in_awready = ($urandom_range(0, 3) != 0);
      in_wready  = ($urandom_range(0, 3) != 0);
      in_arready = ($urandom_range(0, 3) != 0);
      in_bvalid  = (bq.size() > 0) && ($urandom_range(0, 2) != 0);
      in_bid     = (bq.size() > 0) ? bq[0] : 4'd0;
      in_bresp   = 2'b00;
      in_rvalid  = (rq.size() > 0) && ($urandom_range(0, 2) != 0);
      in_rid     = (rq.size() > 0) ? rq[0].id : 4'd0;
      in_rlast   = (rq.size() > 0) ? (rq[0].beat == int'(rq[0].len)) : 1'b0;
      in_rresp   = 2'b00;
      in_rdata   = $urandom;
      #1;
      cf  = in_cmd_valid && out_cmd_ready;
      af  = out_awvalid && in_awready;
      wf  = out_wvalid && in_wready;
      arf = out_arvalid && in_arready;
      bf  = in_bvalid && out_bready;
      rf  = in_rvalid && out_rready;
      if (out_wvalid) chk("rnd_w_after_aw", (m_w.size() != 0), 1);
      if (wf && m_w.size() != 0) begin
        e = m_w[0];
        chk("rnd_wdata", out_wdata, e.addr + 32'(w_beat_m) * 32'd4);
        chk("rnd_wlast", out_wlast, (w_beat_m == int'(e.len)));
        chk("rnd_wid", out_wid, e.id);
        if (w_beat_m == int'(e.len)) begin
          void'(m_w.pop_front());
          bq.push_back(e.id);
          w_beat_m = 0;
        end else begin
          w_beat_m++;
        end
      end
      if (af) begin
        chk("rnd_aw_expected", (m_aw.size() != 0), 1);
        if (m_aw.size() != 0) begin
          e = m_aw.pop_front();
          chk("rnd_awaddr", out_awaddr, e.addr);
          chk("rnd_awlen", out_awlen, e.len);
          chk("rnd_awid", out_awid, e.id);
          m_w.push_back(e);
        end
      end
      if (arf) begin
        chk("rnd_ar_expected", (m_ar.size() != 0), 1);
        if (m_ar.size() != 0) begin
          e = m_ar.pop_front();
          chk("rnd_araddr", out_araddr, e.addr);
          chk("rnd_arlen", out_arlen, e.len);
          chk("rnd_arid", out_arid, e.id);
          rr.id = e.id; rr.len = e.len; rr.beat = 0;
          rq.push_back(rr);
        end
      end
      if (bf && bq.size() != 0) void'(bq.pop_front());
      if (rf && rq.size() != 0) begin
        if (in_rlast) void'(rq.pop_front());
        else rq[0].beat = rq[0].beat + 1;
      end
      if (cf) begin
        e.addr = in_cmd_addr; e.len = in_cmd_len; e.id = in_cmd_id;
        if (in_cmd_write) begin m_aw.push_back(e); n_wr++; end
        else begin m_ar.push_back(e); n_rd++; end
        issued++;
        taken = 1;
      end
      step();
      if (issued == ncmd && m_aw.size() == 0 && m_w.size() == 0 && m_ar.size() == 0 &&
          bq.size() == 0 && rq.size() == 0) begin
        done = 1;
        break;
      end
    end
    clear_inputs();
    #1;
    chk("rnd_drain_in_budget", done, 1);
    chk("rnd_wr_done_cnt", out_wr_done_cnt, 16'(n_wr));
    chk("rnd_rd_done_cnt", out_rd_done_cnt, 16'(n_rd));
    chk("rnd_no_errors", errs(), 5'b0);
  endtask

  wvec_t wv[4];
  rvec_t rv[5];

  initial begin
    int c, issued, awn;
    wv[0] = '{32'h0000_0100, 4'd3,  4'd5, 4'd5, 2'b00, 1'b0, 1'b0};
    wv[1] = '{32'hFFFF_FFF8, 4'd2,  4'd1, 4'd1, 2'b00, 1'b0, 1'b0};
    wv[2] = '{32'h0000_2000, 4'd0,  4'd2, 4'd3, 2'b00, 1'b1, 1'b0};
    wv[3] = '{32'h0000_0040, 4'd15, 4'hF, 4'hF, 2'b10, 1'b0, 1'b1};
    rv[0] = '{32'h300, 4'd2, 4'd3, 4'd3, 3, 2, 2'b00, 1'b0, 1'b0, 1'b0};
    rv[1] = '{32'h300, 4'd2, 4'd3, 4'd3, 2, 1, 2'b00, 1'b0, 1'b1, 1'b0};
    rv[2] = '{32'h010, 4'd0, 4'd3, 4'd7, 1, 0, 2'b00, 1'b1, 1'b0, 1'b0};
    rv[3] = '{32'h010, 4'd1, 4'd2, 4'd2, 2, 1, 2'b11, 1'b0, 1'b0, 1'b1};
    rv[4] = '{32'h020, 4'd1, 4'd9, 4'd9, 3, 2, 2'b00, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_awvalid", out_awvalid, 0);
    chk("rst_wvalid", out_wvalid, 0);
    chk("rst_arvalid", out_arvalid, 0);
    chk("rst_bready", out_bready, 0);
    chk("rst_rready", out_rready, 0);
    chk("rst_wr_cnt", out_wr_done_cnt, 0);
    chk("rst_rd_cnt", out_rd_done_cnt, 0);
    chk("rst_errs", errs(), 5'b0);
    step();
    chk("rel_bready", out_bready, 1);
    chk("rel_rready", out_rready, 1);

    foreach (wv[i]) run_write(wv[i], $sformatf("wv%0d", i));
    // Flags from the last vector must persist until reset
    for (int i = 0; i < 5; i++) step();
    chk("sticky_bresp", out_err_bresp, 1);
    do_reset();
    #1 chk("sticky_bresp_cleared", out_err_bresp, 0);

    foreach (rv[i]) begin
      run_read(rv[i], $sformatf("rv%0d", i));
      if (i == 2) begin
        for (int j = 0; j < 5; j++) step();
        chk("sticky_rid", out_err_rid, 1);
      end
    end

    // AW backpressure: payload held, no W, write command blocked
    do_reset();
    step();
    in_cmd_valid = 1; in_cmd_write = 1; in_cmd_addr = 32'h500; in_cmd_len = 4'd1; in_cmd_id = 4'd2;
    in_wready = 1;
    step();
    in_cmd_valid = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_awvalid", out_awvalid, 1);
      chk("bp_awaddr", out_awaddr, 32'h500);
      chk("bp_no_wvalid", out_wvalid, 0);
      chk("bp_cmd_ready_wr", out_cmd_ready, 0);
      step();
    end
    in_cmd_write = 0;
    #1 chk("bp_cmd_ready_rd", out_cmd_ready, 1);
    in_cmd_write = 1;
    in_awready = 1;
    step();
    in_awready = 0;
    #1;
    c = 0;
    while (!out_wvalid && c < 20) begin step(); #1; c++; end
    chk("bp_w_after_aw", out_wvalid, 1);
    chk("bp_wdata0", out_wdata, 32'h500);

    // Outstanding limit: four AWs, fifth held until a B returns
    do_reset();
    step();
    in_awready = 1; in_wready = 1; in_cmd_write = 1; in_cmd_len = 4'd0;
    issued = 0; awn = 0;
    for (int i = 0; i < 40; i++) begin
      in_cmd_valid = (issued < 5); in_cmd_id = 4'(issued); in_cmd_addr = 32'h1000 + 32'(issued) * 32'h10;
      #1;
      if (in_cmd_valid && out_cmd_ready) issued++;
      if (out_awvalid && in_awready) awn++;
      step();
    end
    #1;
    chk("ostd_aw_count", awn, 4);
    chk("ostd_cmd_blocked", out_cmd_ready, 0);
    for (int i = 0; i < 40; i++) begin
      in_cmd_valid = (issued < 5); in_cmd_id = 4'(issued); in_cmd_addr = 32'h1000 + 32'(issued) * 32'h10;
      in_bvalid = (i == 0); in_bid = 4'd0;
      #1;
      if (in_cmd_valid && out_cmd_ready) issued++;
      if (out_awvalid && in_awready) awn++;
      step();
    end
    in_cmd_valid = 0; in_bvalid = 0;
    #1;
    chk("ostd_fifth_aw", awn, 5);
    chk("ostd_wr_done", out_wr_done_cnt, 16'd1);
    chk("ostd_no_err", errs(), 5'b0);

    // Reset during beat 2 of a len=7 write
    do_reset();
    step();
    in_cmd_valid = 1; in_cmd_write = 1; in_cmd_addr = 32'h800; in_cmd_len = 4'd7; in_cmd_id = 4'd1;
    in_awready = 1; in_wready = 1;
    step();
    in_cmd_valid = 0;
    #1;
    c = 0;
    while (!out_wvalid && c < 20) begin step(); #1; c++; end
    chk("mid_w_start", out_wvalid, 1);
    step();
    step();
    #1 chk("mid_beat2", out_wdata, 32'h808);
    srst = 1;
    step();
    srst = 0;
    #1;
    chk("mid_wvalid", out_wvalid, 0);
    chk("mid_awvalid", out_awvalid, 0);
    chk("mid_wr_cnt", out_wr_done_cnt, 0);
    chk("mid_rd_cnt", out_rd_done_cnt, 0);

    // Randomized traffic right after that reset release
    run_random(60);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
